rsd_hazard_ctrl: RTL and testbench

- Hazard and forwarding controller for the decode-stage operand muxes (RS and RT copies of the 4-way RSD select mux).
- Keeps a shadow pipeline of in-flight destination registers and their ready-times for the E, M and W stages.
- Drives the 2-bit mux selects, and raises stall/bubble on load-use and on HI/LO busy hazards.
- Owns the multiply/divide busy counter.

---
 rtl/rsd_hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_rsd_hazard_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// rsd_hazard_ctrl
//   Hazard and forwarding controller for the decode-stage RS/RT operand muxes.
//   Tracks a shadow copy of the E/M/W destination registers with their
//   remaining result latency, drives the 2-bit operand mux selects and raises
//   stall/bubble on load-use and HI/LO (multiply/divide) busy hazards.
//
//   Build option: RSD_FORWARD_EN
//     defined   : forwarding through the select muxes, stall only when a
//                 producer cannot deliver in time.
//     undefined : selects tied to the regfile, stall on any in-flight writer
//                 (E, M or W) of a source register.
//
// Ports
//   clk, rst_n         pipeline clock, asynchronous active-low reset
//   freeze             global pipeline hold; all state holds, stall/bubble 0
//   rs_d, rt_d         D-stage source register indices
//   tuse_rs, tuse_rt   cycles until the D instruction needs the operand
//                      (3 = never)
//   dst_d, tnew_d      D-stage destination (0 = none) and result latency
//   md_start_d         00 none, 01 mult-class, 10 div-class
//   md_use_d           D instruction touches HI/LO or starts the MD unit
//   sel_rs, sel_rt     operand mux selects: 0 regfile, 1 M ALU result,
//                      2 W write data, 3 E early value
//   stall              hold PC and the D register
//   bubble_e           load a NOP into E this cycle
// ---------------------------------------------------------------------------
module rsd_hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       freeze,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs,
  input  logic [1:0] tuse_rt,
  input  logic [4:0] dst_d,
  input  logic [1:0] tnew_d,
  input  logic [1:0] md_start_d,
  input  logic       md_use_d,
  output logic [1:0] sel_rs,
  output logic [1:0] sel_rt,
  output logic       stall,
  output logic       bubble_e
);

  localparam int MD_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CNT_W  = $clog2(MD_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);

  // Shadow pipeline entries
  logic             e_vld_q, m_vld_q, w_vld_q;
  logic [4:0]       e_dst_q, m_dst_q, w_dst_q;
  logic [1:0]       e_tnew_q, m_tnew_q, w_tnew_q;

  // MD tracking: start flag for the op sitting in E, plus the busy counter
  logic             md_e_q;
  logic             md_div_e_q;
  logic [CNT_W-1:0] md_cnt_q;

  logic rs_hit_e, rs_hit_m, rs_hit_w;
  logic rt_hit_e, rt_hit_m, rt_hit_w;
  logic data_stall;
  logic md_busy;
  logic md_stall;
  logic stall_raw;
  logic unused_ok;

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Register 0 is hard-wired and never produced by anyone.
  function automatic logic hit(input logic v, input logic [4:0] d, input logic [4:0] s);
    return v && (d == s) && (s != 5'd0);
  endfunction

  always_comb begin
    rs_hit_e = hit(e_vld_q, e_dst_q, rs_d);
    rs_hit_m = hit(m_vld_q, m_dst_q, rs_d);
    rs_hit_w = hit(w_vld_q, w_dst_q, rs_d);
    rt_hit_e = hit(e_vld_q, e_dst_q, rt_d);
    rt_hit_m = hit(m_vld_q, m_dst_q, rt_d);
    rt_hit_w = hit(w_vld_q, w_dst_q, rt_d);
  end

`ifdef RSD_FORWARD_EN
  // Youngest matching stage decides; an unready younger producer selects the
  // regfile rather than falling back to a stale older copy.
  function automatic logic [1:0] fwd_sel(input logic he, input logic hm, input logic hw,
                                         input logic [1:0] te, input logic [1:0] tm);
    if (he)      return (te == 2'd0) ? 2'd3 : 2'd0;
    else if (hm) return (tm == 2'd0) ? 2'd1 : 2'd0;
    else if (hw) return 2'd2;
    else         return 2'd0;
  endfunction

  always_comb begin
    sel_rs     = fwd_sel(rs_hit_e, rs_hit_m, rs_hit_w, e_tnew_q, m_tnew_q);
    sel_rt     = fwd_sel(rt_hit_e, rt_hit_m, rt_hit_w, e_tnew_q, m_tnew_q);
    data_stall = (rs_hit_e && (e_tnew_q > tuse_rs)) ||
                 (rs_hit_m && (m_tnew_q > tuse_rs)) ||
                 (rt_hit_e && (e_tnew_q > tuse_rt)) ||
                 (rt_hit_m && (m_tnew_q > tuse_rt));
  end

  // W latency is never consulted: W data is always forwardable.
  assign unused_ok = ^w_tnew_q;
`else
  // No bypass: W is included because same-cycle regfile write/read is not
  // assumed to be transparent.
  always_comb begin
    sel_rs     = 2'd0;
    sel_rt     = 2'd0;
    data_stall = rs_hit_e || rs_hit_m || rs_hit_w ||
                 rt_hit_e || rt_hit_m || rt_hit_w;
  end

  assign unused_ok = ^{w_tnew_q, tuse_rs, tuse_rt};
`endif

  assign md_busy   = (md_cnt_q != '0);
  // An MD op still in E has not loaded the counter yet, so it counts as busy.
  assign md_stall  = md_use_d && (md_busy || md_e_q);
  assign stall_raw = data_stall || md_stall;
  assign stall     = stall_raw && !freeze;
  assign bubble_e  = stall_raw && !freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_vld_q    <= 1'b0;
      e_dst_q    <= 5'd0;
      e_tnew_q   <= 2'd0;
      m_vld_q    <= 1'b0;
      m_dst_q    <= 5'd0;
      m_tnew_q   <= 2'd0;
      w_vld_q    <= 1'b0;
      w_dst_q    <= 5'd0;
      w_tnew_q   <= 2'd0;
      md_e_q     <= 1'b0;
      md_div_e_q <= 1'b0;
      md_cnt_q   <= '0;
    end else if (!freeze) begin
      w_vld_q    <= m_vld_q;
      w_dst_q    <= m_dst_q;
      w_tnew_q   <= dec_sat(m_tnew_q);
      m_vld_q    <= e_vld_q;
      m_dst_q    <= e_dst_q;
      m_tnew_q   <= dec_sat(e_tnew_q);
      e_vld_q    <= !stall_raw;
      e_dst_q    <= dst_d;
      e_tnew_q   <= tnew_d;
      md_e_q     <= !stall_raw && (md_start_d != 2'b00);
      md_div_e_q <= md_start_d[1];
      if (md_e_q) begin
        md_cnt_q <= md_div_e_q ? DIV_LD : MULT_LD;
      end else if (md_busy) begin
        md_cnt_q <= md_cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rsd_hazard_ctrl.sv
module tb_rsd_hazard_ctrl;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       freeze = 1'b0;
  logic [4:0] rs_d = 5'd0;
  logic [4:0] rt_d = 5'd0;
  logic [1:0] tuse_rs = 2'd3;
  logic [1:0] tuse_rt = 2'd3;
  logic [4:0] dst_d = 5'd0;
  logic [1:0] tnew_d = 2'd0;
  logic [1:0] md_start_d = 2'd0;
  logic       md_use_d = 1'b0;
  logic [1:0] sel_rs, sel_rt;
  logic       stall, bubble_e;

  rsd_hazard_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze),
    .rs_d(rs_d), .rt_d(rt_d), .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
    .dst_d(dst_d), .tnew_d(tnew_d), .md_start_d(md_start_d), .md_use_d(md_use_d),
    .sel_rs(sel_rs), .sel_rt(sel_rt), .stall(stall), .bubble_e(bubble_e)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: list of in-flight instructions indexed by age
  // (0 = E, 1 = M, 2 = W), each keeping its ORIGINAL latency; remaining
  // latency is derived from its age. MD busy is an absolute deadline in
  // advance-count time.
  typedef struct {
    bit v;
    int dst;
    int tnew;
    int md;
  } ent_t;

  ent_t st[3];
  int   adv = 0;
  int   md_free_at = 0;

  int e_sel_rs, e_sel_rt;
  bit e_stall, e_stall_raw;
  int o_sel_rs, o_sel_rt, o_stall, o_bubble;

  function automatic int rem(int k);
    return (st[k].tnew - k > 0) ? st[k].tnew - k : 0;
  endfunction

  function automatic bit mt(int k, int src);
    return st[k].v && (st[k].dst == src) && (src != 0);
  endfunction

  function automatic void model_sel(input int src, input int tuse, output int sel, output bit ds);
    sel = 0;
    ds  = 0;
`ifdef RSD_FORWARD_EN
    for (int k = 0; k < 3; k++) begin
      if (mt(k, src)) begin
        if (k == 0)      sel = (rem(0) == 0) ? 3 : 0;
        else if (k == 1) sel = (rem(1) == 0) ? 1 : 0;
        else             sel = 2;
        break;
      end
    end
    for (int k = 0; k < 2; k++)
      if (mt(k, src) && rem(k) > tuse) ds = 1;
`else
    for (int k = 0; k < 3; k++)
      if (mt(k, src)) ds = 1;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) st[k] = '{0, 0, 0, 0};
    adv = 0;
    md_free_at = 0;
  endtask

  task automatic model_eval();
    bit ds_rs, ds_rt, md_e, busy;
    model_sel(int'(rs_d), int'(tuse_rs), e_sel_rs, ds_rs);
    model_sel(int'(rt_d), int'(tuse_rt), e_sel_rt, ds_rt);
    md_e = st[0].v && (st[0].md != 0);
    busy = adv < md_free_at;
    e_stall_raw = ds_rs || ds_rt || (md_use_d && (busy || md_e));
    e_stall = e_stall_raw && !freeze;
  endtask

  task automatic model_adv();
    if (freeze) return;
    model_eval();
    if (st[0].v && st[0].md != 0)
      md_free_at = adv + 1 + ((st[0].md == 2) ? DIV_CYC : MULT_CYC);
    st[2] = st[1];
    st[1] = st[0];
    st[0].v    = !e_stall_raw;
    st[0].dst  = int'(dst_d);
    st[0].tnew = int'(tnew_d);
    st[0].md   = e_stall_raw ? 0 : int'(md_start_d);
    adv++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One pipeline cycle: drive, compare at negedge, advance model at posedge.
  task automatic step(input int rs, input int rt, input int tr, input int tt,
                      input int dst, input int tn, input int mds, input int mdu,
                      input int frz);
    rs_d       = 5'(rs);
    rt_d       = 5'(rt);
    tuse_rs    = 2'(tr);
    tuse_rt    = 2'(tt);
    dst_d      = 5'(dst);
    tnew_d     = 2'(tn);
    md_start_d = 2'(mds);
    md_use_d   = 1'(mdu);
    freeze     = 1'(frz);
    @(negedge clk);
    model_eval();
    o_sel_rs = int'(sel_rs);
    o_sel_rt = int'(sel_rt);
    o_stall  = int'(stall);
    o_bubble = int'(bubble_e);
    chk("sel_rs", o_sel_rs, e_sel_rs);
    chk("sel_rt", o_sel_rt, e_sel_rt);
    chk("stall", o_stall, int'(e_stall));
    chk("bubble_e", o_bubble, int'(e_stall));
    @(posedge clk);
    model_adv();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 3, 3, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset pulse asserted mid-cycle; outputs must clear at once.
  task automatic reset_pulse(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    chk({name, " sel_rs"}, int'(sel_rs), 0);
    chk({name, " sel_rt"}, int'(sel_rt), 0);
    chk({name, " stall"}, int'(stall), 0);
    chk({name, " bubble"}, int'(bubble_e), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  n;
    int  elapsed;
    bit  done;
    int  frz;
    model_reset();
    // Reset state
    @(negedge clk);
    chk("reset sel_rs", int'(sel_rs), 0);
    chk("reset sel_rt", int'(sel_rt), 0);
    chk("reset stall", int'(stall), 0);
    chk("reset bubble", int'(bubble_e), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // No producers
    step(5, 0, 0, 3, 0, 0, 0, 0, 0);
    chk("idle sel_rs", o_sel_rs, 0);
    chk("idle stall", o_stall, 0);

    // ALU producer r8 tnew 1, consumer rs=8 tuse 1
    step(0, 0, 3, 3, 8, 1, 0, 0, 0);
`ifdef RSD_FORWARD_EN
    step(8, 0, 1, 3, 0, 0, 0, 0, 0);
    chk("alu E stall", o_stall, 0);
    chk("alu E sel", o_sel_rs, 0);
    step(8, 0, 1, 3, 0, 0, 0, 0, 0);
    chk("alu M sel", o_sel_rs, 1);
    chk("alu M stall", o_stall, 0);
    step(8, 0, 1, 3, 0, 0, 0, 0, 0);
    chk("alu W sel", o_sel_rs, 2);
`else
    for (int i = 0; i < 4; i++) begin
      step(8, 0, 1, 3, 0, 0, 0, 0, 0);
      chk("nofwd alu stall", o_stall, (i < 3) ? 1 : 0);
      chk("nofwd alu sel", o_sel_rs, 0);
    end
`endif
    idle(3);

    // Load producer r9 tnew 2, consumer rt=9 tuse 1
    step(0, 0, 3, 3, 9, 2, 0, 0, 0);
    step(0, 9, 3, 1, 0, 0, 0, 0, 0);
    chk("load stall", o_stall, 1);
    chk("load bubble", o_bubble, 1);
`ifdef RSD_FORWARD_EN
    step(0, 9, 3, 1, 0, 0, 0, 0, 0);
    chk("load after stall", o_stall, 0);
    step(0, 9, 3, 1, 0, 0, 0, 0, 0);
    chk("load W sel_rt", o_sel_rt, 2);
`else
    for (int i = 0; i < 3; i++) begin
      step(0, 9, 3, 1, 0, 0, 0, 0, 0);
      chk("nofwd load stall", o_stall, (i < 2) ? 1 : 0);
    end
`endif
    idle(3);

    // Youngest producer wins: r3 in M and r3 in E, both ready
    step(0, 0, 3, 3, 3, 0, 0, 0, 0);
    step(0, 0, 3, 3, 3, 0, 0, 0, 0);
    step(3, 0, 0, 3, 0, 0, 0, 0, 0);
`ifdef RSD_FORWARD_EN
    chk("youngest sel_rs", o_sel_rs, 3);
    chk("youngest stall", o_stall, 0);
`else
    chk("nofwd youngest stall", o_stall, 1);
`endif
    idle(3);
    step(0, 0, 3, 3, 0, 0, 0, 0, 0);
    step(0, 0, 0, 3, 0, 0, 0, 0, 0);
    chk("r0 sel_rs", o_sel_rs, 0);
    chk("r0 stall", o_stall, 0);

    // Reset mid-sequence with a stalling producer in E
    idle(3);
    step(0, 0, 3, 3, 5, 2, 0, 0, 0);
    rs_d = 5'd5;
    tuse_rs = 2'd0;
    dst_d = 5'd0;
    #1;
    chk("pre-reset stall", int'(stall), 1);
    reset_pulse("midreset");
    step(5, 0, 0, 3, 0, 0, 0, 0, 0);
    chk("post-reset stall", o_stall, 0);

    // div then mfhi
    idle(3);
    step(0, 0, 3, 3, 0, 0, 2, 0, 0);
    n = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(0, 0, 3, 3, 0, 0, 0, 1, 0);
      if (o_stall != 0) n++;
      else done = 1;
    end
    chk("div stall cycles", n, 1 + DIV_CYC);

    // div with a 3-cycle freeze in the middle of the count
    step(0, 0, 3, 3, 0, 0, 2, 0, 0);
    elapsed = -1;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      frz = (i >= 4 && i < 7) ? 1 : 0;
      step(0, 0, 3, 3, 0, 0, 0, 1, frz);
      if (frz != 0) chk("frozen stall", o_stall, 0);
      else if (o_stall == 0) begin
        elapsed = i;
        done = 1;
      end
    end
    chk("div freeze span", elapsed, 1 + DIV_CYC + 3);

    // mult then mfhi
    step(0, 0, 3, 3, 0, 0, 1, 0, 0);
    n = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(0, 0, 3, 3, 0, 0, 0, 1, 0);
      if (o_stall != 0) n++;
      else done = 1;
    end
    chk("mult stall cycles", n, 1 + MULT_CYC);

    // Reset during an MD count leaves no residual busy
    step(0, 0, 3, 3, 0, 0, 2, 0, 0);
    step(0, 0, 3, 3, 0, 0, 0, 1, 0);
    step(0, 0, 3, 3, 0, 0, 0, 1, 0);
    chk("md busy before reset", o_stall, 1);
    reset_pulse("mdreset");
    step(0, 0, 3, 3, 0, 0, 0, 1, 0);
    chk("md after reset", o_stall, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_pulse("rnd reset");
      end else begin
        step($urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 7), $urandom_range(0, 3),
             ($urandom_range(0, 15) == 0) ? $urandom_range(1, 2) : 0,
             ($urandom_range(0, 3) == 0) ? 1 : 0,
             ($urandom_range(0, 7) == 0) ? 1 : 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
